// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-to-hazard-controller signal bundle.
// Ports/signals:
//   ID stage   : D_Rs, D_Rt, D_UseRs, D_UseRt
//   EX stage   : E_Rd, E_Wreg, E_Reg2reg, E_Btaken
//   MEM stage  : M_Rd, M_Wreg, M_Reg2reg, M_MemReq, Mem_ack
//   controls   : PC_We, IF_ID_We, IF_ID_Flush, ID_EX_We, Stall, FwdA, FwdB
//   status     : Mem_err (timeout pulse), Stall_cnt (saturating stall count)
// master = pipeline side, slave = hazard controller.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0]       D_Rs, D_Rt, E_Rd, M_Rd;
    logic             D_UseRs, D_UseRt;
    logic             E_Wreg, E_Reg2reg, E_Btaken;
    logic             M_Wreg, M_Reg2reg, M_MemReq, Mem_ack;
    logic             PC_We, IF_ID_We, IF_ID_Flush, ID_EX_We, Stall, Mem_err;
    logic [1:0]       FwdA, FwdB;
    logic [CNT_W-1:0] Stall_cnt;

    modport master (
        output D_Rs, D_Rt, D_UseRs, D_UseRt,
        output E_Rd, E_Wreg, E_Reg2reg, E_Btaken,
        output M_Rd, M_Wreg, M_Reg2reg, M_MemReq, Mem_ack,
        input  PC_We, IF_ID_We, IF_ID_Flush, ID_EX_We, Stall, FwdA, FwdB,
        input  Mem_err, Stall_cnt
    );

    modport slave (
        input  D_Rs, D_Rt, D_UseRs, D_UseRt,
        input  E_Rd, E_Wreg, E_Reg2reg, E_Btaken,
        input  M_Rd, M_Wreg, M_Reg2reg, M_MemReq, Mem_ack,
        output PC_We, IF_ID_We, IF_ID_Flush, ID_EX_We, Stall, FwdA, FwdB,
        output Mem_err, Stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/sequencing controller for the 5-stage pipeline.
// Ports:
//   Clk  : rising-edge clock
//   Clrn : asynchronous active-low reset
//   bus  : pipe_hazard_ctrl_if.slave -- stage operands in; register enables,
//          bubble/flush, forward selects, Mem_err pulse and Stall_cnt out.
// Parameters: MEM_TIMEOUT (max MEM_WAIT cycles), CNT_W (Stall_cnt width).
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input logic              Clk,
    input logic              Clrn,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_t;

    state_t           state, state_nx;
    logic [WC_W-1:0]  wcnt, wcnt_nx;
    logic [CNT_W-1:0] cnt;
    logic             lu, frozen;
    logic             pc_we, if_id_we, if_id_flush, id_ex_we, stall;

    // EX result forwards only for non-loads; a load still in EX falls through
    // to whatever MEM holds. Register 0 never forwards.
    function automatic logic [1:0] fwd(
        input logic [4:0] src,
        input logic [4:0] e_rd, input logic e_w, input logic e_r2r,
        input logic [4:0] m_rd, input logic m_w, input logic m_r2r
    );
        if (src == 5'd0)                    return 2'b00;
        if (e_w && e_rd == src && !e_r2r)   return 2'b01;
        if (m_w && m_rd == src)             return m_r2r ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        state_nx    = RUN;
        wcnt_nx     = '0;
        lu          = bus.E_Wreg && bus.E_Reg2reg && bus.E_Rd != 5'd0 &&
                      ((bus.D_UseRs && bus.D_Rs == bus.E_Rd) ||
                       (bus.D_UseRt && bus.D_Rt == bus.E_Rd));
        // the access freezes the pipe in the very cycle it misses its ack
        frozen      = (state == MEM_WAIT) ||
                      (state == RUN && bus.M_MemReq && !bus.Mem_ack);
        // a taken branch discards the ID instruction, so it beats load-use
        pc_we       = !frozen && (bus.E_Btaken || !lu);
        if_id_we    = pc_we;
        id_ex_we    = !frozen;
        stall       = !frozen && (bus.E_Btaken || lu);
        if_id_flush = !frozen && bus.E_Btaken;
        if (state == RUN && frozen) begin
            state_nx = MEM_WAIT;
            wcnt_nx  = WC_W'(1);
        end else if (state == MEM_WAIT && !bus.Mem_ack) begin
            if (wcnt == WC_W'(MEM_TIMEOUT - 1)) begin
                state_nx = MEM_ERR;
            end else begin
                state_nx = MEM_WAIT;
                wcnt_nx  = wcnt + WC_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state <= RUN;
            wcnt  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            if ((!pc_we || stall) && !(&cnt))
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.PC_We       = pc_we;
    assign bus.IF_ID_We    = if_id_we;
    assign bus.IF_ID_Flush = if_id_flush;
    assign bus.ID_EX_We    = id_ex_we;
    assign bus.Stall       = stall;
    assign bus.FwdA        = fwd(bus.D_Rs, bus.E_Rd, bus.E_Wreg, bus.E_Reg2reg,
                                 bus.M_Rd, bus.M_Wreg, bus.M_Reg2reg);
    assign bus.FwdB        = fwd(bus.D_Rt, bus.E_Rd, bus.E_Wreg, bus.E_Reg2reg,
                                 bus.M_Rd, bus.M_Wreg, bus.M_Reg2reg);
    assign bus.Mem_err     = state == MEM_ERR;
    assign bus.Stall_cnt   = cnt;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Drives the write-enables of the PC, IF_ID and ID_EX registers and the bubble-insert (stall) line of ID_EX.
- Generates the 2-bit FwdA/FwdB selects that ID_EX carries into EX.
- Freezes the whole pipeline while a data-memory access waits for its acknowledge, with a timeout, and keeps a saturating stall-cycle counter.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles spent in MEM_WAIT before the access is abandoned.
- CNT_W, 16, width of the Stall_cnt counter.

Ports:
- Clk  in  1  clock, rising edge.
- Clrn  in  1  asynchronous active-low reset.
- D_Rs  in  5  source register 1 of the instruction in ID.
- D_Rt  in  5  source register 2 of the instruction in ID.
- D_UseRs  in  1  ID instruction reads Rs.
- D_UseRt  in  1  ID instruction reads Rt.
- E_Rd  in  5  destination register in EX.
- E_Wreg  in  1  EX instruction writes the register file.
- E_Reg2reg  in  1  EX writeback is from memory (load).
- M_Rd  in  5  destination register in MEM.
- M_Wreg  in  1  MEM instruction writes the register file.
- M_Reg2reg  in  1  MEM writeback is from memory.
- E_Btaken  in  1  branch/jump resolved taken in EX.
- M_MemReq  in  1  MEM stage issuing a data-memory access.
- Mem_ack  in  1  data memory access complete.
- PC_We  out  1  PC register enable.
- IF_ID_We  out  1  IF_ID register enable.
- IF_ID_Flush  out  1  IF_ID clear.
- ID_EX_We  out  1  ID_EX We.
- Stall  out  1  ID_EX stall (clear → bubble).
- FwdA  out  2  forward select for operand A.
- FwdB  out  2  forward select for operand B.
- Mem_err  out  1  one-cycle pulse on memory timeout.
- Stall_cnt  out  CNT_W  total frozen or bubbled cycles, saturating.

Behaviour:
- Reset (Clrn=0, async): state=RUN, wait counter=0, Stall_cnt=0, Mem_err=0.
- Combinational outputs follow the RUN rules during reset.
- States:
  - RUN.
  - MEM_WAIT.
  - MEM_ERR (exactly one cycle, then RUN).
- Forwarding (combinational, ID-stage, evaluated independently for Rs→FwdA and Rt→FwdB):
  - 01 if E_Wreg and E_Rd==src and not E_Reg2reg.
  - Else 11 if M_Wreg, M_Rd==src and M_Reg2reg.
  - Else 10 if M_Wreg and M_Rd==src.
  - Else 00.
  - src==0 always gives 00.
  - The EX match has priority over the MEM match.
- Load-use (RUN): lu = E_Wreg & E_Reg2reg & E_Rd!=0 & ((D_UseRs & D_Rs==E_Rd) | (D_UseRt & D_Rt==E_Rd)).
  - When lu: Stall=1, PC_We=0, IF_ID_We=0, ID_EX_We=1.
  - Exactly one bubble. The next cycle resolves through FwdA/FwdB=11.
- Branch (RUN): E_Btaken gives IF_ID_Flush=1 and Stall=1.
  - PC_We=1 and IF_ID_We=1.
  - Overrides lu, because the ID instruction is discarded.
- Memory wait:
  - In RUN, M_MemReq & !Mem_ack freezes the pipeline in the same cycle: PC_We=IF_ID_We=ID_EX_We=0, Stall=0, IF_ID_Flush=0.
  - Next state is MEM_WAIT with wait counter=1.
  - The freeze has priority over branch and lu, which are re-evaluated after release because the inputs are held.
- In MEM_WAIT, all enables stay 0:
  - Mem_ack=1 → this cycle still frozen, next state RUN.
  - Else, counter==MEM_TIMEOUT-1 → next state MEM_ERR.
  - Else, counter+1.
- MEM_ERR: Mem_err=1, enables follow RUN rules, wait counter cleared.
- Mem_ack in the same cycle as M_MemReq in RUN: no freeze.
- Stall_cnt increments on any cycle with PC_We=0 or Stall=1 and saturates at all-ones.
- Clrn low mid-wait aborts to RUN immediately.

Test Plan:
- Forwarding: E: Rd=5, Wreg=1, Reg2reg=0; M: Rd=5, Wreg=1; ID Rs=5, Rt=0 → FwdA=01, FwdB=00, no stall. Set E_Wreg=0, M_Reg2reg=1 → FwdA=11.
- Load-use: E load Rd=3; ID uses Rt=3 → one cycle with Stall=1, PC_We=0, IF_ID_We=0. Next cycle (bubble in E, load in M) → FwdB=11, Stall=0. Stall_cnt=1.
- Branch during load-use: E_Btaken=1 with lu=1 → IF_ID_Flush=1, Stall=1, PC_We=1.
- Memory wait: M_MemReq=1, Mem_ack arrives 4 cycles later → enables 0 for 5 cycles, then resume. Stall_cnt=5.
- Timeout: MEM_TIMEOUT=16, Mem_ack never → Mem_err pulses once, 16 cycles after the request. Subsequent cycle in RUN.
- Reset mid-wait: Clrn low in cycle 3 of MEM_WAIT → immediately RUN, Stall_cnt=0. Rs=0 with E_Rd=0, E_Wreg=1 → FwdA=00.
